// File: rtl/ysyx_22050133_axi_sram_slave.sv
// AXI4 slave backed by an on-chip 64-bit word memory.
// Independent single-outstanding read and write burst engines.
module ysyx_22050133_axi_sram_slave #(
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_WORDS      = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        axi_aw_ready_o,
    input  logic                        axi_aw_valid_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_aw_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i,
    input  logic [7:0]                  axi_aw_len_i,
    input  logic [2:0]                  axi_aw_size_i,
    input  logic [1:0]                  axi_aw_burst_i,
    output logic                        axi_w_ready_o,
    input  logic                        axi_w_valid_i,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i,
    input  logic                        axi_w_last_i,
    input  logic                        axi_b_ready_i,
    output logic                        axi_b_valid_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_b_id_o,
    output logic [1:0]                  axi_b_resp_o,
    output logic                        axi_ar_ready_o,
    input  logic                        axi_ar_valid_i,
    input  logic [AXI_ID_WIDTH-1:0]     axi_ar_id_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_i,
    input  logic [7:0]                  axi_ar_len_i,
    input  logic [2:0]                  axi_ar_size_i,
    input  logic [1:0]                  axi_ar_burst_i,
    input  logic                        axi_r_ready_i,
    output logic                        axi_r_valid_o,
    output logic [AXI_ID_WIDTH-1:0]     axi_r_id_o,
    output logic [1:0]                  axi_r_resp_o,
    output logic [AXI_DATA_WIDTH-1:0]   axi_r_data_o,
    output logic                        axi_r_last_o
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [AXI_ADDR_WIDTH:0] LIMIT = (AXI_ADDR_WIDTH+1)'(MEM_WORDS) << 3;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [AXI_ADDR_WIDTH-1:0] a,
        input logic [2:0]                sz,
        input logic [1:0]                bu
    );
        logic [1:0] s;
        s = (sz > 3'd3) ? 2'd3 : sz[1:0];
        return (bu == 2'b00) ? a : a + (AXI_ADDR_WIDTH'(1) << s);
    endfunction

    function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
        return {1'b0, a} < LIMIT;
    endfunction

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    wstate_t w_state, w_next;
    rstate_t r_state, r_next;

    logic [AXI_ID_WIDTH-1:0]   w_id, r_id;
    logic [AXI_ADDR_WIDTH-1:0] w_addr, r_addr;
    logic [7:0]                w_len, r_len, w_cnt, r_cnt;
    logic [2:0]                w_size, r_size;
    logic [1:0]                w_burst, r_burst;
    logic                      w_err;

    logic aw_hs, w_hs, ar_hs, r_hs, w_end;

    assign aw_hs = axi_aw_valid_i & axi_aw_ready_o;
    assign w_hs  = axi_w_valid_i & axi_w_ready_o;
    assign ar_hs = axi_ar_valid_i & axi_ar_ready_o;
    assign r_hs  = axi_r_ready_i & axi_r_valid_o;
    assign w_end = (w_cnt == w_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next         = w_state;
        axi_aw_ready_o = 1'b0;
        axi_w_ready_o  = 1'b0;
        axi_b_valid_o  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                axi_aw_ready_o = 1'b1;
                if (axi_aw_valid_i) w_next = W_DATA;
            end
            W_DATA: begin
                axi_w_ready_o = 1'b1;
                if (axi_w_valid_i && w_end) w_next = W_RESP;
            end
            W_RESP: begin
                axi_b_valid_o = 1'b1;
                if (axi_b_ready_i) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        r_next         = r_state;
        axi_ar_ready_o = 1'b0;
        axi_r_valid_o  = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                axi_ar_ready_o = 1'b1;
                if (axi_ar_valid_i) r_next = R_DATA;
            end
            R_DATA: begin
                axi_r_valid_o = 1'b1;
                if (axi_r_ready_i && r_cnt == r_len) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= axi_aw_id_i;
            w_addr  <= axi_aw_addr_i;
            w_len   <= axi_aw_len_i;
            w_size  <= axi_aw_size_i;
            w_burst <= axi_aw_burst_i;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_addr <= next_addr(w_addr, w_size, w_burst);
            w_cnt  <= w_cnt + 8'd1;
            // last-flag disagreement is reported but the counter still ends the burst
            if (!in_range(w_addr) || (axi_w_last_i != w_end)) w_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else if (ar_hs) begin
            r_id    <= axi_ar_id_i;
            r_addr  <= axi_ar_addr_i;
            r_len   <= axi_ar_len_i;
            r_size  <= axi_ar_size_i;
            r_burst <= axi_ar_burst_i;
            r_cnt   <= '0;
        end else if (r_hs) begin
            r_addr <= next_addr(r_addr, r_size, r_burst);
            r_cnt  <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_hs && in_range(w_addr)) begin
            for (int i = 0; i < AXI_DATA_WIDTH/8; i++) begin
                if (axi_w_strb_i[i])
                    mem[w_addr[IDX_W+2:3]][8*i +: 8] <= axi_w_data_i[8*i +: 8];
            end
        end
    end

    // asynchronous read gives pre-write data on a same-cycle collision
    always_comb begin
        axi_r_data_o = '0;
        if (axi_r_valid_o && in_range(r_addr))
            axi_r_data_o = mem[r_addr[IDX_W+2:3]];
    end

    assign axi_r_resp_o = (axi_r_valid_o && !in_range(r_addr)) ? 2'b10 : 2'b00;
    assign axi_r_last_o = axi_r_valid_o && (r_cnt == r_len);
    assign axi_r_id_o   = axi_r_valid_o ? r_id : '0;
    assign axi_b_resp_o = (axi_b_valid_o && w_err) ? 2'b10 : 2'b00;
    assign axi_b_id_o   = axi_b_valid_o ? w_id : '0;

endmodule

// File: tb/tb_ysyx_22050133_axi_sram_slave.sv
// Directed bench for the AXI SRAM slave with a reference memory
// and expected-response queues for the B and R channels.
module tb_ysyx_22050133_axi_sram_slave;
    logic        clk, rst;
    logic        aw_ready, aw_valid;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_ready, w_valid, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_ready, b_valid;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        ar_ready, ar_valid;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_ready, r_valid, r_last;
    logic [3:0]  r_id;
    logic [1:0]  r_resp;
    logic [63:0] r_data;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;
    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [63:0] mdl [4096];
    int          total = 0;
    int          bad = 0;

    ysyx_22050133_axi_sram_slave dut (
        .clk(clk), .rst(rst),
        .axi_aw_ready_o(aw_ready), .axi_aw_valid_i(aw_valid),
        .axi_aw_id_i(aw_id), .axi_aw_addr_i(aw_addr),
        .axi_aw_len_i(aw_len), .axi_aw_size_i(aw_size),
        .axi_aw_burst_i(aw_burst),
        .axi_w_ready_o(w_ready), .axi_w_valid_i(w_valid),
        .axi_w_data_i(w_data), .axi_w_strb_i(w_strb),
        .axi_w_last_i(w_last),
        .axi_b_ready_i(b_ready), .axi_b_valid_o(b_valid),
        .axi_b_id_o(b_id), .axi_b_resp_o(b_resp),
        .axi_ar_ready_o(ar_ready), .axi_ar_valid_i(ar_valid),
        .axi_ar_id_i(ar_id), .axi_ar_addr_i(ar_addr),
        .axi_ar_len_i(ar_len), .axi_ar_size_i(ar_size),
        .axi_ar_burst_i(ar_burst),
        .axi_r_ready_i(r_ready), .axi_r_valid_o(r_valid),
        .axi_r_id_o(r_id), .axi_r_resp_o(r_resp),
        .axi_r_data_o(r_data), .axi_r_last_o(r_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] sz,
                                        input logic [1:0] bu);
        int s;
        s = (sz > 3) ? 3 : int'(sz);
        if (bu == 2'b00) return a;
        return a + (32'd1 << s);
    endfunction

    function automatic bit inr(input logic [31:0] a);
        return a < 32'h8000;
    endfunction

    task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bu, input logic [63:0] base,
                      input logic [7:0] strb, input bit badlast);
        logic [31:0] a;
        logic [63:0] d;
        bit          err;
        int          n;
        bexp_t       be;
        a = addr;
        err = badlast;
        for (int k = 0; k <= int'(len); k++) begin
            d = base + 64'(k);
            if (!inr(a)) err = 1;
            else for (int i = 0; i < 8; i++)
                if (strb[i]) mdl[a[14:3]][8*i +: 8] = d[8*i +: 8];
            a = nxt(a, sz, bu);
        end
        be.id = id;
        be.resp = err ? 2'b10 : 2'b00;
        bq.push_back(be);
        @(negedge clk);
        aw_id = id; aw_addr = addr; aw_len = len;
        aw_size = sz; aw_burst = bu; aw_valid = 1;
        n = 0;
        while (!aw_ready && n < 50) begin @(negedge clk); n++; end
        chk("aw_hs", 64'(n < 50), 1);
        @(negedge clk);
        aw_valid = 0;
        for (int k = 0; k <= int'(len); k++) begin
            w_valid = 1;
            w_data = base + 64'(k);
            w_strb = strb;
            w_last = badlast ? (k == 0) : (k == int'(len));
            n = 0;
            while (!w_ready && n < 50) begin @(negedge clk); n++; end
            chk("w_hs", 64'(n < 50), 1);
            @(negedge clk);
        end
        w_valid = 0;
        w_last = 0;
        chk("b_valid_next", b_valid, 1);
        b_ready = 1;
        be = bq.pop_front();
        chk("b_resp", b_resp, be.resp);
        chk("b_id", b_id, be.id);
        @(negedge clk);
        b_ready = 0;
        chk("b_drop", b_valid, 0);
    endtask

    task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input logic [2:0] sz, input logic [1:0] bu, input bit stall);
        logic [31:0] a;
        logic [63:0] hv;
        rexp_t       e;
        bit          tog, held;
        int          n;
        a = addr;
        for (int k = 0; k <= int'(len); k++) begin
            e.data = inr(a) ? mdl[a[14:3]] : 64'd0;
            e.resp = inr(a) ? 2'b00 : 2'b10;
            e.last = (k == int'(len));
            e.id = id;
            rq.push_back(e);
            a = nxt(a, sz, bu);
        end
        @(negedge clk);
        ar_id = id; ar_addr = addr; ar_len = len;
        ar_size = sz; ar_burst = bu; ar_valid = 1;
        n = 0;
        while (!ar_ready && n < 50) begin @(negedge clk); n++; end
        chk("ar_hs", 64'(n < 50), 1);
        @(negedge clk);
        ar_valid = 0;
        chk("r_first", r_valid, 1);
        tog = 0; held = 0; hv = '0; n = 0;
        while (rq.size() > 0 && n < 200) begin
            r_ready = stall ? tog : 1'b1;
            tog = !tog;
            if (held) begin
                chk("r_stall_valid", r_valid, 1);
                chk("r_stall_data", r_data, hv);
                held = 0;
            end
            if (r_valid && r_ready) begin
                e = rq.pop_front();
                chk("r_data", r_data, e.data);
                chk("r_resp", r_resp, e.resp);
                chk("r_last", r_last, e.last);
                chk("r_id", r_id, e.id);
            end else if (r_valid) begin
                hv = r_data;
                held = 1;
            end
            @(negedge clk);
            n++;
        end
        r_ready = 0;
        chk("r_all_beats", 64'(rq.size()), 0);
        chk("r_idle_valid", r_valid, 0);
        chk("r_idle_ar_ready", ar_ready, 1);
        rq.delete();
    endtask

    initial begin
        rst = 1;
        aw_valid = 0; aw_id = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_id = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        r_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_aw_ready", aw_ready, 1);
        chk("rst_ar_ready", ar_ready, 1);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_b_resp", b_resp, 0);
        chk("rst_r_resp", r_resp, 0);
        chk("rst_b_id", b_id, 0);
        chk("rst_r_id", r_id, 0);
        chk("rst_r_last", r_last, 0);
        chk("rst_r_data", r_data, 0);
        rst = 0;

        wr(4'd1, 32'h10, 8'd0, 3'd3, 2'b01, 64'h1122334455667788, 8'hFF, 0);
        rd(4'd2, 32'h10, 8'd0, 3'd3, 2'b01, 0);

        wr(4'd3, 32'h100, 8'd3, 3'd3, 2'b01, 64'hA0, 8'hFF, 0);
        rd(4'd5, 32'h100, 8'd3, 3'd3, 2'b01, 1);

        wr(4'd0, 32'h20, 8'd0, 3'd3, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        wr(4'd0, 32'h20, 8'd0, 3'd3, 2'b01, 64'h0, 8'h0F, 0);
        rd(4'd1, 32'h20, 8'd0, 3'd3, 2'b01, 0);

        wr(4'd4, 32'h0, 8'd0, 3'd3, 2'b01, 64'h5A5A_5A5A_5A5A_5A5A, 8'hFF, 0);
        wr(4'd6, 32'h8000, 8'd1, 3'd3, 2'b01, 64'h77, 8'hFF, 0);
        rd(4'd6, 32'h8000, 8'd1, 3'd3, 2'b01, 0);
        rd(4'd7, 32'h0, 8'd0, 3'd3, 2'b01, 0);

        wr(4'd2, 32'h30, 8'd1, 3'd3, 2'b01, 64'h300, 8'hFF, 1);
        rd(4'd2, 32'h30, 8'd1, 3'd3, 2'b01, 0);

        wr(4'd4, 32'h40, 8'd2, 3'd3, 2'b00, 64'h40, 8'hFF, 0);
        rd(4'd4, 32'h40, 8'd2, 3'd7, 2'b00, 1);

        wr(4'd8, 32'h200, 8'd7, 3'd3, 2'b01, 64'hC0, 8'hFF, 0);
        @(negedge clk);
        aw_id = 9; aw_addr = 32'h400; aw_len = 3; aw_size = 3; aw_burst = 1; aw_valid = 1;
        @(negedge clk);
        aw_valid = 0;
        chk("mid_w_ready", w_ready, 1);
        w_valid = 1; w_data = 64'hDEAD; w_strb = 8'hFF; w_last = 0;
        mdl[128] = 64'hDEAD;
        @(negedge clk);
        w_valid = 0;
        ar_id = 3; ar_addr = 32'h200; ar_len = 7; ar_size = 3; ar_burst = 1; ar_valid = 1;
        @(negedge clk);
        ar_valid = 0;
        r_ready = 1;
        for (int k = 0; k < 2; k++) begin
            chk("mid_r_beat", r_data, mdl[64+k]);
            @(negedge clk);
        end
        chk("mid_r_beat2", r_data, mdl[66]);
        rst = 1;
        @(negedge clk);
        chk("mid_rst_r_valid", r_valid, 0);
        chk("mid_rst_w_ready", w_ready, 0);
        chk("mid_rst_ar_ready", ar_ready, 1);
        chk("mid_rst_aw_ready", aw_ready, 1);
        chk("mid_rst_b_valid", b_valid, 0);
        rst = 0;
        r_ready = 0;
        rd(4'd3, 32'h200, 8'd7, 3'd3, 2'b01, 0);
        rd(4'd9, 32'h400, 8'd0, 3'd3, 2'b01, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
